// File: rtl/pc_seq.sv
// Program counter sequencer: jump/call/return/increment with a LIFO return stack.
// Optional stack-fault trap with freeze is enabled by defining PC_SEQ_TRAP_EN.
module pc_seq #(
    parameter int unsigned AW       = 4,
    parameter int unsigned SD       = 4,
    parameter logic [AW-1:0] RST_ADDR = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     load_n,
    input  logic [AW-1:0]            in,
    input  logic                     call,
    input  logic                     ret,
    output logic [AW-1:0]            out_addr,
    output logic [$clog2(SD+1)-1:0]  level,
    output logic                     full,
    output logic                     empty,
    output logic                     err
);

    localparam int unsigned LW    = $clog2(SD + 1);
    localparam int unsigned IW    = (SD > 1) ? $clog2(SD) : 1;
    localparam int unsigned DEPTH = 2 ** IW;

    // Return stack storage; entries at or above level are never read.
    logic [AW-1:0] stack [DEPTH];

    logic [AW-1:0] pc_nxt;
    logic [LW-1:0] lvl_nxt;
    logic          err_nxt;
    logic          push;
    logic [AW-1:0] pc_inc;
    logic [IW-1:0] push_idx;
    logic [IW-1:0] pop_idx;

    assign pc_inc   = AW'(out_addr + 1'b1);
    assign push_idx = IW'(level);
    assign pop_idx  = IW'(level - 1'b1);

    // Next-state selection in priority order: jump, call, return, increment.
    always_comb begin
        pc_nxt  = out_addr;
        lvl_nxt = level;
        err_nxt = err;
        push    = 1'b0;
        if (en && !err) begin
            if (!load_n) begin
                pc_nxt = in;
            end else if (call) begin
                if (!full) begin
                    push    = 1'b1;
                    lvl_nxt = LW'(level + 1'b1);
                    pc_nxt  = in;
                end else begin
`ifdef PC_SEQ_TRAP_EN
                    err_nxt = 1'b1;
`else
                    pc_nxt  = in;
`endif
                end
            end else if (ret) begin
                if (!empty) begin
                    pc_nxt  = stack[pop_idx];
                    lvl_nxt = LW'(level - 1'b1);
                end else begin
`ifdef PC_SEQ_TRAP_EN
                    err_nxt = 1'b1;
`else
                    pc_nxt  = pc_inc;
`endif
                end
            end else begin
                pc_nxt = pc_inc;
            end
        end
    end

    // PC, level and registered level decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_addr <= RST_ADDR;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            out_addr <= pc_nxt;
            level    <= lvl_nxt;
            full     <= (lvl_nxt == LW'(SD));
            empty    <= (lvl_nxt == '0);
        end
    end

`ifdef PC_SEQ_TRAP_EN
    // Sticky fault flag; once set it also freezes all sequencing state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= err_nxt;
        end
    end
`else
    assign err = 1'b0;
`endif

    // Stack contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            stack[push_idx] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: directed literal checks plus randomized stimulus
// compared every cycle against a queue-based behavioural model.
module tb_pc_seq;

    localparam int unsigned AW  = 4;
    localparam int unsigned SD  = 4;
    localparam int unsigned LW  = $clog2(SD + 1);
    localparam int          RST = 0;
    localparam int          MOD = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en = 1'b0;
    logic          load_n = 1'b1;
    logic [AW-1:0] din = '0;
    logic          call = 1'b0;
    logic          ret = 1'b0;
    logic [AW-1:0] out_addr;
    logic [LW-1:0] level;
    logic          full;
    logic          empty;
    logic          err;

    int total = 0;
    int bad   = 0;
    bit cmp_on = 1'b0;

    pc_seq #(.AW(AW), .SD(SD), .RST_ADDR(AW'(RST))) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load_n(load_n), .in(din),
        .call(call), .ret(ret), .out_addr(out_addr), .level(level),
        .full(full), .empty(empty), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural model: PC as an integer, return stack as a queue.
    int m_pc  = RST;
    int m_stk[$];
    bit m_err = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = RST;
            m_stk.delete();
            m_err = 1'b0;
        end else if (en && !m_err) begin
            if (!load_n) begin
                m_pc = int'(din);
            end else if (call) begin
                if (m_stk.size() < SD) begin
                    m_stk.push_back((m_pc + 1) % MOD);
                    m_pc = int'(din);
                end else begin
`ifdef PC_SEQ_TRAP_EN
                    m_err = 1'b1;
`else
                    m_pc = int'(din);
`endif
                end
            end else if (ret) begin
                if (m_stk.size() > 0) begin
                    m_pc = m_stk.pop_back();
                end else begin
`ifdef PC_SEQ_TRAP_EN
                    m_err = 1'b1;
`else
                    m_pc = (m_pc + 1) % MOD;
`endif
                end
            end else begin
                m_pc = (m_pc + 1) % MOD;
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            check("model_pc",    int'(out_addr), m_pc);
            check("model_level", int'(level),    m_stk.size());
            check("model_full",  int'(full),     int'(m_stk.size() == SD));
            check("model_empty", int'(empty),    int'(m_stk.size() == 0));
            check("model_err",   int'(err),      int'(m_err));
        end
    end

    // Drive one cycle of inputs at a falling edge and return at the next one.
    task automatic drive(input bit e, input bit l_n, input bit c, input bit r, input int a);
        en = e; load_n = l_n; call = c; ret = r; din = AW'(a);
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int hold_pc;
    int hold_lvl;

    initial begin
        en = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cmp_on = 1'b1;

        // Reset values and increment wrap.
        check("rst_pc",    int'(out_addr), 0);
        check("rst_level", int'(level),    0);
        check("rst_empty", int'(empty),    1);
        check("rst_full",  int'(full),     0);
        check("rst_err",   int'(err),      0);
        for (int i = 1; i <= 16; i++) begin
            drive(1, 1, 0, 0, 0);
            check("wrap_pc", int'(out_addr), i % 16);
            check("wrap_level", int'(level), 0);
        end

        // Jump beats call.
        drive(1, 0, 0, 0, 5);
        check("jump_pc5", int'(out_addr), 5);
        drive(1, 0, 1, 0, 9);
        check("jump_pri_pc", int'(out_addr), 9);
        check("jump_pri_level", int'(level), 0);

        // Call / return.
        drive(1, 0, 0, 0, 3);
        drive(1, 1, 1, 0, 12);
        check("call_pc", int'(out_addr), 12);
        check("call_level", int'(level), 1);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        check("call_inc_pc", int'(out_addr), 14);
        drive(1, 1, 0, 1, 0);
        check("ret_pc", int'(out_addr), 4);
        check("ret_level", int'(level), 0);
        check("ret_empty", int'(empty), 1);

        // Nesting to full, then unwind.
        drive(1, 0, 0, 0, 1);
        drive(1, 1, 1, 0, 3);
        drive(1, 1, 1, 0, 5);
        drive(1, 1, 1, 0, 7);
        drive(1, 1, 1, 1, 11);
        check("nest_level", int'(level), 4);
        check("nest_full", int'(full), 1);
        check("nest_pc", int'(out_addr), 11);
`ifndef PC_SEQ_TRAP_EN
        drive(1, 1, 1, 0, 0);
        check("full_call_pc", int'(out_addr), 0);
        check("full_call_level", int'(level), 4);
`endif
        drive(1, 1, 0, 1, 0);
        check("unwind_pc0", int'(out_addr), 8);
        drive(1, 1, 0, 1, 0);
        check("unwind_pc1", int'(out_addr), 6);
        drive(1, 1, 0, 1, 0);
        check("unwind_pc2", int'(out_addr), 4);
        drive(1, 1, 0, 1, 0);
        check("unwind_pc3", int'(out_addr), 2);
        check("unwind_empty", int'(empty), 1);

        // Return on empty stack.
        drive(1, 0, 0, 0, 6);
        drive(1, 1, 0, 1, 0);
`ifdef PC_SEQ_TRAP_EN
        check("fault_err", int'(err), 1);
        check("fault_pc", int'(out_addr), 6);
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 0, 0);
            check("frozen_pc", int'(out_addr), 6);
        end
        reset_pulse();
        check("fault_rst_pc", int'(out_addr), RST);
        check("fault_rst_err", int'(err), 0);
`else
        check("empty_ret_pc", int'(out_addr), 7);
        check("empty_ret_err", int'(err), 0);
`endif

        // Hold with en low, then asynchronous reset mid-cycle.
        drive(1, 0, 0, 0, 10);
        drive(1, 1, 1, 0, 2);
        hold_pc  = int'(out_addr);
        hold_lvl = int'(level);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 0, 13);
            check("hold_pc", int'(out_addr), hold_pc);
            check("hold_level", int'(level), hold_lvl);
        end
        en = 1'b1; call = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pc", int'(out_addr), RST);
        check("async_rst_level", int'(level), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset_pulse();
            end else begin
                drive($urandom_range(0, 9) != 0,
                      $urandom_range(0, 9) != 0,
                      $urandom_range(0, 3) == 0,
                      $urandom_range(0, 2) == 0,
                      int'($urandom_range(0, MOD - 1)));
            end
        end

        cmp_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
